nnrv_if_fq: RTL and testbench

//  Parametrised instruction-fetch stage with a prefetch queue. Issues word reads to instruction RAM

---
 rtl/nnrv_pkg.sv | 15 +
 rtl/nnrv_sync_fifo.sv | 54 +++++
 rtl/nnrv_if_fq.sv | 114 +++++++++++
 tb/tb_nnrv_if_fq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nnrv_pkg.sv
// Shared defaults and helpers for the nnrv fetch path.
package nnrv_pkg;

  localparam int unsigned DefInstrWidth = 32;
  localparam int unsigned DefAddrWidth  = 8;
  localparam int unsigned DefXlen       = 32;
  localparam logic [31:0] DefNopInstr   = 32'h0000_0013;

  // A fetch-queue entry is {instr, pc}.
  function automatic int unsigned fq_entry_width(int unsigned instr_width,
                                                 int unsigned addr_width);
    return instr_width + addr_width;
  endfunction

endpackage

// File: rtl/nnrv_sync_fifo.sv
// Synchronous FIFO with flush; flush wins over push, reset wins over everything.
module nnrv_sync_fifo
  import nnrv_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so push is legal when full and popping.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !flush && !i_rst) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/nnrv_if_fq.sv
// Instruction fetch with a prefetch queue: issues RAM word reads ahead of decode and
// hands {instr, pc} to ID; a jump flushes the queue and refetches from the target.
module nnrv_if_fq
  import nnrv_pkg::*;
#(
  parameter int unsigned             INSTR_WIDTH = DefInstrWidth,
  parameter int unsigned             ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned             XLEN        = DefXlen,
  parameter int unsigned             FQ_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = INSTR_WIDTH'(DefNopInstr)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic [ADDR_WIDTH-1:0]  o_ram_rd_addr,
  output logic                   o_ram_rd_en,
  output logic [3:0]             o_ram_rd_mask,
  input  logic [INSTR_WIDTH-1:0] i_ram_rd_data,
  output logic [INSTR_WIDTH-1:0] o_id_instr,
  output logic [XLEN-1:0]        o_id_cur_pc,
  output logic                   o_id_valid,
  input  logic                   i_id_stall,
  input  logic                   i_id_jmp_stall,
  input  logic [XLEN-1:0]        i_id_jmp_pc
);

  localparam int unsigned EntryW = fq_entry_width(INSTR_WIDTH, ADDR_WIDTH);
  localparam int unsigned CntW   = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned SumW   = CntW + 1;
  localparam logic [ADDR_WIDTH-1:0] PcStep = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] jmp_addr, rd_addr;
  logic                  jmp, issue, credit_ok;
  logic [SumW-1:0]       used;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]       fifo_count;
  logic [EntryW-1:0]     fifo_wdata, fifo_rdata;

  // Bits outside the word address of the jump target are dropped on purpose.
  logic unused_sigs;
  assign unused_sigs = ^{fifo_full, i_id_jmp_pc};

  assign jmp      = i_id_jmp_stall && !i_rst;
  assign jmp_addr = {i_id_jmp_pc[ADDR_WIDTH-1:2], 2'b00};

  // Credit counts queue slots plus the outstanding read so a returning word always fits.
  assign used      = SumW'(fifo_count) + SumW'(inflight_q);
  assign credit_ok = (used < SumW'(FQ_DEPTH));

  always_comb begin
    issue         = 1'b0;
    rd_addr       = pc_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    if (jmp) begin
      issue   = 1'b1;
      rd_addr = jmp_addr;
    end else if (!i_rst && credit_ok) begin
      issue = 1'b1;
    end
    if (issue) begin
      pc_d          = rd_addr + PcStep;
      inflight_pc_d = rd_addr;
    end
  end

  assign inflight_d = issue;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign o_ram_rd_en   = issue;
  assign o_ram_rd_addr = rd_addr;
  assign o_ram_rd_mask = 4'b1111;

  // Data returning during a redirect belongs to the abandoned stream.
  assign fifo_push  = inflight_q && !jmp && !i_rst;
  assign fifo_wdata = {i_ram_rd_data, inflight_pc_q};
  assign fifo_pop   = o_id_valid && !i_id_stall;

  nnrv_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (jmp),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_id_valid  = !fifo_empty && !jmp && !i_rst;
  assign o_id_instr  = o_id_valid ? fifo_rdata[EntryW-1:ADDR_WIDTH] : NOP_INSTR;
  assign o_id_cur_pc = o_id_valid ? XLEN'(fifo_rdata[ADDR_WIDTH-1:0]) : '0;

endmodule

// File: tb/tb_nnrv_if_fq.sv
// Bench for nnrv_if_fq: queue-level reference model checked every cycle, a pop
// scoreboard, and directed literal checks for the listed scenarios.
module tb_nnrv_if_fq;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned XL = 32;
  localparam int unsigned D  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          i_clk;
  logic          i_rst;
  logic [AW-1:0] o_ram_rd_addr;
  logic          o_ram_rd_en;
  logic [3:0]    o_ram_rd_mask;
  logic [IW-1:0] i_ram_rd_data;
  logic [IW-1:0] o_id_instr;
  logic [XL-1:0] o_id_cur_pc;
  logic          o_id_valid;
  logic          i_id_stall;
  logic          i_id_jmp_stall;
  logic [XL-1:0] i_id_jmp_pc;

  nnrv_if_fq dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_ram_rd_addr  (o_ram_rd_addr),
    .o_ram_rd_en    (o_ram_rd_en),
    .o_ram_rd_mask  (o_ram_rd_mask),
    .i_ram_rd_data  (i_ram_rd_data),
    .o_id_instr     (o_id_instr),
    .o_id_cur_pc    (o_id_cur_pc),
    .o_id_valid     (o_id_valid),
    .i_id_stall     (i_id_stall),
    .i_id_jmp_stall (i_id_jmp_stall),
    .i_id_jmp_pc    (i_id_jmp_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] memf(logic [7:0] a);
    return {8'hA5, 16'h0000, a};
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Instruction RAM: one-cycle read latency, poison when no request.
  always @(posedge i_clk) begin
    if (o_ram_rd_en) i_ram_rd_data <= memf(o_ram_rd_addr);
    else             i_ram_rd_data <= 32'hDEAD_BEEF;
  end

  // Reference model: queue of buffered pcs, one outstanding read, next fetch pc.
  int  m_q[$];
  int  m_pc = 0;
  bit  m_infl = 0;
  int  m_infl_pc = 0;
  int  popped[$];
  bit  sb_pend = 1;
  int  sb_target = 0;
  int  sb_last = 0;

  bit  exp_en, exp_valid;
  int  exp_addr, exp_head, ja;

  always @(negedge i_clk) begin
    ja = int'(i_id_jmp_pc[7:0]) & 32'hFC;
    exp_head = 0;
    if (i_rst) begin
      exp_en = 0; exp_valid = 0; exp_addr = 0;
    end else if (i_id_jmp_stall) begin
      exp_en = 1; exp_valid = 0; exp_addr = ja;
    end else begin
      exp_valid = (m_q.size() > 0);
      if (exp_valid) exp_head = m_q[0];
      exp_en   = (int'(D) - m_q.size() - int'(m_infl)) > 0;
      exp_addr = m_pc;
    end

    check("rd_en", 64'(o_ram_rd_en), 64'(exp_en));
    if (exp_en) check("rd_addr", 64'(o_ram_rd_addr), 64'(exp_addr));
    check("rd_mask", 64'(o_ram_rd_mask), 64'h0F);
    check("id_valid", 64'(o_id_valid), 64'(exp_valid));
    check("id_pc", 64'(o_id_cur_pc), exp_valid ? 64'(exp_head) : 64'd0);
    check("id_instr", 64'(o_id_instr), exp_valid ? 64'(memf(8'(exp_head))) : 64'(NOP));

    // Scoreboard over what ID actually consumes.
    if (!i_rst && !i_id_jmp_stall && o_id_valid && !i_id_stall) begin
      popped.push_back(int'(o_id_cur_pc));
      check("sb_instr", 64'(o_id_instr), 64'(memf(o_id_cur_pc[7:0])));
      if (sb_pend) check("sb_first_pc", 64'(o_id_cur_pc), 64'(sb_target));
      else         check("sb_seq_pc", 64'(o_id_cur_pc), 64'((sb_last + 4) & 255));
      sb_last = int'(o_id_cur_pc);
      sb_pend = 0;
    end
    if (i_rst) begin
      sb_pend = 1; sb_target = 0;
    end else if (i_id_jmp_stall) begin
      sb_pend = 1; sb_target = ja;
    end

    // Advance the model to the next cycle.
    if (i_rst) begin
      m_q.delete(); m_infl = 0; m_pc = 0;
    end else if (i_id_jmp_stall) begin
      m_q.delete(); m_infl = 1; m_infl_pc = ja; m_pc = (ja + 4) & 255;
    end else begin
      if (exp_valid && !i_id_stall) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl = exp_en;
      if (exp_en) begin
        m_infl_pc = m_pc;
        m_pc = (m_pc + 4) & 255;
      end
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  int idx;

  initial begin
    i_rst = 1'b1; i_id_stall = 1'b0; i_id_jmp_stall = 1'b0; i_id_jmp_pc = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Reset release: back-to-back fetch, head appears two cycles after first issue.
    @(negedge i_clk);
    check("t1_c0_en", 64'(o_ram_rd_en), 64'd1);
    check("t1_c0_addr", 64'(o_ram_rd_addr), 64'h00);
    check("t1_c0_valid", 64'(o_id_valid), 64'd0);
    @(negedge i_clk);
    check("t1_c1_addr", 64'(o_ram_rd_addr), 64'h04);
    @(negedge i_clk);
    check("t1_c2_valid", 64'(o_id_valid), 64'd1);
    check("t1_c2_pc", 64'(o_id_cur_pc), 64'h00);
    check("t1_c2_instr", 64'(o_id_instr), 64'hA500_0000);
    @(negedge i_clk);
    check("t1_c3_pc", 64'(o_id_cur_pc), 64'h04);
    check("t1_c3_instr", 64'(o_id_instr), 64'hA500_0004);
    repeat (4) @(negedge i_clk);

    // Stall 10 cycles: queue fills, fetch stops, head holds.
    next_cycle(); i_id_stall = 1'b1;
    @(negedge i_clk);
    check("t2_head_first", 64'(o_id_cur_pc), 64'h18);
    repeat (9) @(negedge i_clk);
    check("t2_en_off", 64'(o_ram_rd_en), 64'd0);
    check("t2_head_hold", 64'(o_id_cur_pc), 64'h18);
    check("t2_instr_hold", 64'(o_id_instr), 64'hA500_0018);
    next_cycle(); i_id_stall = 1'b0;
    @(negedge i_clk);
    check("t2_rel_pc0", 64'(o_id_cur_pc), 64'h18);
    @(negedge i_clk);
    check("t2_rel_pc1", 64'(o_id_cur_pc), 64'h1C);
    check("t2_rel_en", 64'(o_ram_rd_en), 64'd1);
    check("t2_rel_addr", 64'(o_ram_rd_addr), 64'h28);
    repeat (4) @(negedge i_clk);

    // Fill the queue, then jump to 0x40.
    next_cycle(); i_id_stall = 1'b1;
    repeat (6) @(negedge i_clk);
    check("t3_full_en", 64'(o_ram_rd_en), 64'd0);
    next_cycle(); i_id_stall = 1'b0; i_id_jmp_stall = 1'b1; i_id_jmp_pc = 32'h40;
    @(negedge i_clk);
    check("t3_jmp_valid", 64'(o_id_valid), 64'd0);
    check("t3_jmp_addr", 64'(o_ram_rd_addr), 64'h40);
    next_cycle(); i_id_jmp_stall = 1'b0;
    @(negedge i_clk);
    check("t3_j1_valid", 64'(o_id_valid), 64'd0);
    check("t3_j1_addr", 64'(o_ram_rd_addr), 64'h44);
    @(negedge i_clk);
    check("t3_j2_pc", 64'(o_id_cur_pc), 64'h40);
    check("t3_j2_instr", 64'(o_id_instr), 64'hA500_0040);
    @(negedge i_clk);
    check("t3_j3_pc", 64'(o_id_cur_pc), 64'h44);
    repeat (3) @(negedge i_clk);

    // Jump with stall, then back-to-back jumps; upper target bits are truncated.
    next_cycle(); i_id_stall = 1'b1; i_id_jmp_stall = 1'b1; i_id_jmp_pc = 32'hFFFF_FF80;
    @(negedge i_clk);
    check("t4_js_valid", 64'(o_id_valid), 64'd0);
    check("t4_js_addr", 64'(o_ram_rd_addr), 64'h80);
    next_cycle(); i_id_stall = 1'b0; i_id_jmp_pc = 32'h10;
    @(negedge i_clk);
    check("t4_j10_addr", 64'(o_ram_rd_addr), 64'h10);
    idx = popped.size();
    next_cycle(); i_id_jmp_pc = 32'h20;
    @(negedge i_clk);
    check("t4_j20_addr", 64'(o_ram_rd_addr), 64'h20);
    next_cycle(); i_id_jmp_stall = 1'b0;
    repeat (4) @(negedge i_clk);
    check("t4_pop0", 64'(popped.size() > idx ? popped[idx] : -1), 64'h20);
    check("t4_pop1", 64'(popped.size() > idx + 1 ? popped[idx+1] : -1), 64'h24);

    // Misaligned target near the top of the address space wraps to 0.
    next_cycle(); i_id_jmp_stall = 1'b1; i_id_jmp_pc = 32'hFD;
    @(negedge i_clk);
    check("t5_addr_fc", 64'(o_ram_rd_addr), 64'hFC);
    next_cycle(); i_id_jmp_stall = 1'b0;
    @(negedge i_clk);
    check("t5_wrap_en", 64'(o_ram_rd_en), 64'd1);
    check("t5_wrap_addr", 64'(o_ram_rd_addr), 64'h00);
    @(negedge i_clk);
    check("t5_head_fc", 64'(o_id_cur_pc), 64'hFC);
    check("t5_instr_fc", 64'(o_id_instr), 64'hA500_00FC);
    @(negedge i_clk);
    check("t5_head_00", 64'(o_id_cur_pc), 64'h00);
    repeat (3) @(negedge i_clk);

    // One-cycle reset mid-stream.
    next_cycle(); i_rst = 1'b1;
    @(negedge i_clk);
    check("t6_rst_en", 64'(o_ram_rd_en), 64'd0);
    check("t6_rst_valid", 64'(o_id_valid), 64'd0);
    check("t6_rst_instr", 64'(o_id_instr), 64'(NOP));
    next_cycle(); i_rst = 1'b0;
    @(negedge i_clk);
    check("t6_r0_valid", 64'(o_id_valid), 64'd0);
    check("t6_r0_addr", 64'(o_ram_rd_addr), 64'h00);
    @(negedge i_clk);
    @(negedge i_clk);
    check("t6_r2_pc", 64'(o_id_cur_pc), 64'h00);
    check("t6_r2_instr", 64'(o_id_instr), 64'hA500_0000);
    repeat (6) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
